// File: rtl/image_cache_unloader.sv
// Streams the whole 2D image cache out in raster order over a ready/wanted word stream.
// Reads have one-cycle latency; returned words land in a 2-entry skid FIFO so stalls lose nothing.
module image_cache_unloader #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ROW_WIDTH = 64,
  parameter int unsigned COL_WIDTH = 48,
  parameter int unsigned X_BITS    = 6,
  parameter int unsigned Y_BITS    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 re,
  output logic [X_BITS-1:0]    raddrX,
  output logic [Y_BITS-1:0]    raddrY,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] data,
  output logic                 data_ready,
  input  logic                 data_wanted
);

  localparam int unsigned CNT_BITS = 2;
  localparam int unsigned OCC_BITS = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nx;
  logic [CNT_BITS-1:0]   fifo_cnt, fifo_cnt_nx;
  logic                  inflight;
  logic [WORD_SIZE-1:0]  skid, skid_nx, data_nx;
  logic [X_BITS-1:0]     x_nx;
  logic [Y_BITS-1:0]     y_nx;
  logic [OCC_BITS-1:0]   occ;
  logic                  pop, push, last_x, last_addr, done_nx, busy_nx;

  assign pop       = data_ready & data_wanted;
  assign push      = inflight;
  assign last_x    = (raddrX == X_BITS'(ROW_WIDTH - 1));
  assign last_addr = last_x && (raddrY == Y_BITS'(COL_WIDTH - 1));

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign occ = OCC_BITS'(fifo_cnt) + OCC_BITS'(inflight) - OCC_BITS'(pop);
  assign re  = (state == RUN) && (occ < OCC_BITS'(2));

  always_comb begin
    state_nx    = state;
    x_nx        = raddrX;
    y_nx        = raddrY;
    fifo_cnt_nx = fifo_cnt;
    data_nx     = data;
    skid_nx     = skid;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      RUN: begin
        if (re) begin
          if (last_addr) state_nx = DRAIN;
          if (last_x) begin
            x_nx = '0;
            y_nx = last_addr ? '0 : raddrY + Y_BITS'(1);
          end else begin
            x_nx = raddrX + X_BITS'(1);
          end
        end
      end
      DRAIN: begin
        if (fifo_cnt == '0 && !inflight) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Head register plus one skid slot; the head always holds the oldest word.
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt == '0) data_nx = rdata;
        else                skid_nx = rdata;
        fifo_cnt_nx = fifo_cnt + CNT_BITS'(1);
      end
      2'b01: begin
        if (fifo_cnt == CNT_BITS'(2)) data_nx = skid;
        fifo_cnt_nx = fifo_cnt - CNT_BITS'(1);
      end
      2'b11: begin
        if (fifo_cnt == CNT_BITS'(2)) begin
          data_nx = skid;
          skid_nx = rdata;
        end else begin
          data_nx = rdata;
        end
      end
      default: ;
    endcase

    // done fires as the pipeline empties in DRAIN; busy falls together with it.
    done_nx = (state_nx == DRAIN) && (fifo_cnt_nx == '0) && !re;
    busy_nx = (state_nx != IDLE) && !done_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      raddrX     <= '0;
      raddrY     <= '0;
      fifo_cnt   <= '0;
      inflight   <= 1'b0;
      data       <= '0;
      skid       <= '0;
      data_ready <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overflow_chk: assert (!(push && !pop && fifo_cnt == CNT_BITS'(2)));
      state      <= state_nx;
      raddrX     <= x_nx;
      raddrY     <= y_nx;
      fifo_cnt   <= fifo_cnt_nx;
      inflight   <= re;
      data       <= data_nx;
      skid       <= skid_nx;
      data_ready <= (fifo_cnt_nx != '0);
      done       <= done_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_image_cache_unloader.sv
// Directed bench for image_cache_unloader on a 4x3 image where word(x,y) = 16*y + x.
module tb_image_cache_unloader;

  localparam int unsigned WS = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned XB = 2;
  localparam int unsigned YB = 2;
  localparam int          N  = RW * CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, re, data_ready;
  logic          data_wanted = 1'b0;
  logic [XB-1:0] raddrX;
  logic [YB-1:0] raddrY;
  logic [WS-1:0] rdata = '0;
  logic [WS-1:0] data;

  image_cache_unloader #(
    .WORD_SIZE(WS), .ROW_WIDTH(RW), .COL_WIDTH(CW), .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .re(re), .raddrX(raddrX), .raddrY(raddrY), .rdata(rdata),
    .data(data), .data_ready(data_ready), .data_wanted(data_wanted)
  );

  always #5 clk = ~clk;

  // Cache model: synchronous read, one-cycle latency.
  always @(posedge clk) if (re) rdata <= 32'(16 * int'(raddrY) + int'(raddrX));

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  int got_q[$];
  int got_cyc[$];
  int addr_q[$];
  int done_q[$];
  int re_cnt, issued, popped, max_out;

  // Transaction monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (issued - popped > max_out) max_out = issued - popped;
      if (data_ready && data_wanted) begin
        got_q.push_back(int'(data));
        got_cyc.push_back(cyc);
        popped++;
      end
      if (re) begin
        addr_q.push_back(16 * int'(raddrY) + int'(raddrX));
        re_cnt++;
        issued++;
      end
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); got_cyc.delete(); addr_q.delete(); done_q.delete();
    re_cnt = 0; issued = 0; popped = 0; max_out = 0;
  endtask

  function automatic int exp_word(input int i);
    return 16 * (i / RW) + (i % RW);
  endfunction

  // Pulses start during one cycle (c0); returns at c1 with c0 reported.
  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
    check({tag, "_done_seen"}, done_q.size(), 1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_count"}, got_q.size(), N);
    for (int i = 0; i < got_q.size() && i < N; i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_word(i));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_re"}, int'(re), 0);
    check({tag, "_data_ready"}, int'(data_ready), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_raddrX"}, int'(raddrX), 0);
    check({tag, "_raddrY"}, int'(raddrY), 0);
    check({tag, "_data"}, int'(data), 0);
  endtask

  int c0, rel, re_hi, bad_hold;

  initial begin
    clear_mon();
    repeat (2) tick();
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Free run with the consumer always willing.
    data_wanted = 1'b1;
    clear_mon();
    pulse_start(c0);
    check("free_c1_busy", int'(busy), 1);
    check("free_c1_re", int'(re), 1);
    check("free_c1_addr", 16 * int'(raddrY) + int'(raddrX), 0);
    wait_done("free", 40);
    repeat (3) tick();
    check_seq("free");
    if (got_cyc.size() == N) begin
      check("free_first_cyc", got_cyc[0] - c0, 3);
      check("free_last_cyc", got_cyc[N-1] - c0, 14);
    end
    if (done_q.size() > 0) check("free_done_cyc", done_q[0] - c0, 15);
    check("free_re_count", re_cnt, N);
    check("free_busy_after", int'(busy), 0);

    // Boundary wrap of the issued addresses.
    check("wrap_addr_count", addr_q.size(), N);
    if (addr_q.size() == N) begin
      check("wrap_addr3", addr_q[3], 3);
      check("wrap_addr4", addr_q[4], 16);
      check("wrap_addr_last", addr_q[N-1], 35);
    end
    check("wrap_max_outstanding", int'(max_out <= 2), 1);

    // Back-pressure: consumer toggles every cycle.
    clear_mon();
    data_wanted = 1'b1;
    pulse_start(c0);
    for (int i = 0; i < 80 && done_q.size() == 0; i++) begin
      data_wanted = ~data_wanted;
      tick();
    end
    check("bp_done_seen", done_q.size(), 1);
    data_wanted = 1'b1;
    repeat (3) tick();
    check_seq("bp");
    check("bp_max_outstanding", int'(max_out <= 2), 1);
    if (done_q.size() > 0 && got_cyc.size() == N)
      check("bp_done_after_last", done_q[0] - got_cyc[N-1], 1);

    // Long stall from c3 for ten cycles.
    clear_mon();
    data_wanted = 1'b0;
    pulse_start(c0);
    tick();
    tick();
    re_hi = 0;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (re) re_hi++;
      if (!data_ready || data !== '0) bad_hold++;
      tick();
    end
    check("stall_re_low", re_hi, 0);
    check("stall_hold_word0", bad_hold, 0);
    check("stall_no_accept", got_q.size(), 0);
    data_wanted = 1'b1;
    wait_done("stall", 40);
    repeat (2) tick();
    check_seq("stall");
    if (got_cyc.size() == N) begin
      check("stall_release_cyc0", got_cyc[0] - c0, 13);
      check("stall_release_cyc1", got_cyc[1] - c0, 14);
      check("stall_release_cyc2", got_cyc[2] - c0, 15);
    end

    // Start re-asserted at c5 and at the done cycle is ignored.
    clear_mon();
    data_wanted = 1'b1;
    pulse_start(c0);
    rel = 1;
    while (rel < 30) begin
      tick();
      rel = cyc - c0;
      start = (rel == 5 || rel == 15);
    end
    start = 1'b0;
    check("ign_count", got_q.size(), N);
    check("ign_re_count", re_cnt, N);
    check("ign_done_count", done_q.size(), 1);
    check("ign_busy", int'(busy), 0);
    clear_mon();
    pulse_start(c0);
    wait_done("restart", 40);
    repeat (2) tick();
    check_seq("restart");

    // Asynchronous reset in the middle of an unload.
    clear_mon();
    pulse_start(c0);
    for (int i = 0; i < 40 && got_q.size() < 5; i++) tick();
    check("rst_fifth_word", got_q.size() >= 5 ? got_q[4] : -1, 16);
    #3;
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    tick();
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (4) tick();
    check("rst_no_stale", got_q.size(), 0);
    pulse_start(c0);
    wait_done("rst_rerun", 40);
    repeat (2) tick();
    check_seq("rst_rerun");
    if (got_cyc.size() > 0) check("rst_rerun_first_cyc", got_cyc[0] - c0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/image_cache_unloader.md
# image_cache_unloader

Streams the full contents of the 2D image cache out in raster order over the `data`/`data_ready`/`data_wanted` word-stream handshake. It is the read-side counterpart of the cache loader. It sits between the image cache read port and any downstream consumer, such as a DMA or output port. It issues synchronous reads with one-cycle latency and buffers returned words in a 2-entry skid FIFO, so back-pressure never loses data and sustained throughput is one word per cycle.

## Interface
Parameters:
- `WORD_SIZE`, 32: width of a cache word and of the output stream.
- `ROW_WIDTH`, 64: words per row, i.e. the X extent.
- `COL_WIDTH`, 48: rows per image, i.e. the Y extent.
- `X_BITS`, 6: width of `raddrX`; must satisfy 2^X_BITS ≥ ROW_WIDTH.
- `Y_BITS`, 6: width of `raddrY`; must satisfy 2^Y_BITS ≥ COL_WIDTH.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an unload; sampled only in IDLE.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse when the last word has been accepted.
- `re`  out  1  cache read enable.
- `raddrX`  out  X_BITS  read column.
- `raddrY`  out  Y_BITS  read row.
- `rdata`  in  WORD_SIZE  cache read data; valid the cycle after `re`.
- `data`  out  WORD_SIZE  stream word, the FIFO head.
- `data_ready`  out  1  `data` is valid (FIFO non-empty).
- `data_wanted`  in  1  consumer accepts the word when it and `data_ready` are both high.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE + `start` → RUN; X and Y counters are cleared to 0.
  - `start` is ignored in RUN and DRAIN.
- **Pop:** `pop = data_ready & data_wanted`. The FIFO advances on `pop`.
- **Read issue in RUN:** `re = (fifo_cnt + inflight - pop) < 2`.
  - `inflight` is a 1-bit register equal to the previous cycle's `re`.
  - The returned `rdata` is pushed into the FIFO in the cycle where `inflight` = 1.
- **Addressing:** `raddrX`/`raddrY` are the current counters.
  - When `re` fires, X increments.
  - At X = ROW_WIDTH-1, X wraps to 0 and Y increments.
- **End of issue:** when `re` fires at (ROW_WIDTH-1, COL_WIDTH-1), the FSM goes RUN → DRAIN. `re` is 0 in DRAIN and IDLE.
- **End of unload:** in DRAIN, when the FIFO is empty and `inflight` = 0, `done` pulses for one cycle and the FSM goes to IDLE. `busy` drops in that same cycle.
- **Simultaneous push and pop:** `fifo_cnt` is unchanged and the head advances.
  - The FIFO can never overflow; the issue rule guarantees this.
  - An overflow is a checker error.
- **Output ordering:** `data` presents words in strict raster order: Y-major, X-minor.
- **`data` when empty:** `data` holds its last value while `data_ready` = 0. Its content is don't-care.
- **Reset:** asynchronous reset at any time, including mid-unload, forces:
  - state IDLE;
  - counters 0;
  - FIFO flushed, `fifo_cnt` 0;
  - `inflight` 0;
  - outputs `re` 0, `data_ready` 0, `done` 0, `busy` 0, `raddrX` 0, `raddrY` 0, `data` 0.
  - A cache read returning after reset is discarded.

## Timing
- Cycle numbering, for `start` high at cycle c0 in IDLE:
  - c1: `busy` = 1, `re` = 1, address (0,0).
  - c2: `rdata` is valid and is pushed.
  - c3: `data_ready` = 1, `data` = word(0,0).
- With `data_wanted` held high, one word transfers per cycle from c3 through c3+N-1, where N = ROW_WIDTH·COL_WIDTH.
  - `done` pulses at c3+N.
  - Back in IDLE at c3+N+1, a new `start` is accepted there.
- Latency from `data_wanted` rising to the first transfer is 0 cycles whenever `data_ready` is already high.
- Under stall with `data_wanted` = 0, at most 2 words are buffered and `re` stays low. Issue resumes in the same cycle as the next `pop`.
- `done` and `busy` are registered; `re` is combinational from registered state and `data_wanted`.

## Test plan
All tests use ROW_WIDTH=4, COL_WIDTH=3, with the cache preloaded so word(x,y) = 16·y + x.
- **Free run:** `start` pulse, `data_wanted` held at 1 → 12 words 0,1,2,3,16,…,35 on consecutive cycles c3..c14; `done` at c15; `re` asserted exactly 12 times.
- **Back-pressure:** `data_wanted` toggles 1/0 every cycle → same 12 values in order, no duplicates; `fifo_cnt` ≤ 2 throughout; `done` one cycle after the 12th accept.
- **Long stall:** `data_wanted` = 0 for 10 cycles starting at c3 → `data_ready` = 1 with `data` = 0 held; `re` low from c3 on; on release, words 0,1,2 stream out back-to-back.
- **Ignored start:** `start` re-asserted at c5 and at the `done` cycle → no restart; output is exactly 12 words. A `start` in IDLE afterwards produces the full sequence again.
- **Reset mid-operation:** `reset` asserted asynchronously after the 5th word (value 16) → all outputs 0 immediately. After release and a new `start`, the sequence begins again at 0 and no stale word appears.
- **Boundary wrap:** check the addresses at issue → (3,0) is followed by (0,1); the transition to DRAIN happens on (3,2); no read is issued beyond (3,2).
